rambus_ram: RTL and testbench

Word-organised RAM responder sitting on the processor's rambus, on the opposite end of the processor's RAM interface. It decodes `bus_addr`, commits byte-lane writes under `bus_wstrb`, and returns the full aligned word on `bus_rdata`; lane shifting and sign extension remain the initiator's job. After every reset it scrubs itself to zero, reports busy while doing so, and latches the first out-of-range access in a sticky error register.

---
 rtl/rambus_ram_if.sv | 29 ++
 rtl/rambus_ram.sv | 148 ++++++++++++++
 tb/tb_rambus_ram.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rambus_ram_if.sv
// rambus_ram_if: bus bundle between the processor's RAM interface (master)
// and the rambus_ram responder (slave).
//   bus_addr/bus_re/bus_we/bus_wstrb/bus_wdata : request from the initiator
//   bus_rdata                                  : aligned read word (combinational)
//   busy                                       : responder is scrubbing
//   err/err_addr                               : sticky out-of-range flag and address
//   err_clr                                    : initiator clears the error record
interface rambus_ram_if;
  logic [31:0] bus_addr;
  logic        bus_re;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        busy;
  logic        err;
  logic [31:0] err_addr;
  logic        err_clr;

  modport master (
    output bus_addr, bus_re, bus_we, bus_wstrb, bus_wdata, err_clr,
    input  bus_rdata, busy, err, err_addr
  );

  modport slave (
    input  bus_addr, bus_re, bus_we, bus_wstrb, bus_wdata, err_clr,
    output bus_rdata, busy, err, err_addr
  );
endinterface

// File: rtl/rambus_ram.sv
// rambus_ram: word-organised RAM responder on the processor's rambus.
// Decodes bus_addr against BASE_ADDR, commits byte-lane writes, returns the
// full aligned word combinationally. After every reset it scrubs all DEPTH
// words to zero (busy high), then services one access per cycle. The first
// out-of-range access is latched in a sticky err/err_addr record.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rambus_ram_if.slave (request, read data, busy, error record)
module rambus_ram #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  rambus_ram_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {SCRUB = 1'b0, READY = 1'b1} state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] scrub_idx_r;
  logic [31:0]   mem_r [DEPTH];
  logic          err_r;
  logic [31:0]   err_addr_r;

  logic [31:0]   off_s;
  logic          hit_s;
  logic [AW-1:0] idx_s;
  logic          busy_s;
  logic          rd_en_s;
  logic          wr_en_s;
  logic          err_set_s;
  logic [31:0]   rdata_s;

  // Address decode: wrap-around subtraction makes addresses below the base
  // land far out of range; the byte offset bits never reach the index.
  always_comb begin
    off_s = bus.bus_addr - BASE_ADDR;
    hit_s = ((off_s >> (AW + 2)) == 32'h0);
    idx_s = off_s[AW+1:2];
  end

  // State register: reset always restarts the scrub.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SCRUB;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: leave SCRUB on the edge that clears the last word.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SCRUB: begin
        if (scrub_idx_r == AW'(DEPTH - 1)) begin
          state_nxt_s = READY;
        end else begin
          state_nxt_s = SCRUB;
        end
      end
      READY:   state_nxt_s = READY;
      default: state_nxt_s = SCRUB;
    endcase
  end

  // Output/enable logic: all accesses are gated by READY.
  always_comb begin
    busy_s    = 1'b1;
    rd_en_s   = 1'b0;
    wr_en_s   = 1'b0;
    err_set_s = 1'b0;
    case (state_r)
      SCRUB: begin
        busy_s = 1'b1;
      end
      READY: begin
        busy_s  = 1'b0;
        rd_en_s = bus.bus_re & hit_s;
        wr_en_s = bus.bus_we & hit_s;
        // A new error overrides a pending record only when it is being cleared.
        err_set_s = (bus.bus_re | bus.bus_we) & ~hit_s & (~err_r | bus.err_clr);
      end
      default: begin
        busy_s = 1'b1;
      end
    endcase
  end

  // Scrub index: counts through the array while scrubbing, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scrub_idx_r <= '0;
    end else if (state_r == SCRUB) begin
      scrub_idx_r <= scrub_idx_r + AW'(1);
    end else begin
      scrub_idx_r <= scrub_idx_r;
    end
  end

  // Memory array: no reset, the scrub is its only initialisation.
  always_ff @(posedge clk) begin
    if (state_r == SCRUB) begin
      mem_r[scrub_idx_r] <= 32'h0000_0000;
    end else if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.bus_wstrb[i]) begin
          mem_r[idx_s][8*i +: 8] <= bus.bus_wdata[8*i +: 8];
        end
      end
    end
  end

  // Sticky error record: a new error takes precedence over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r      <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end else if (err_set_s) begin
      err_r      <= 1'b1;
      err_addr_r <= bus.bus_addr;
    end else if (bus.err_clr) begin
      err_r      <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end else begin
      err_r      <= err_r;
      err_addr_r <= err_addr_r;
    end
  end

  // Read mux: zero whenever no valid in-range read is presented.
  always_comb begin
    if (rd_en_s) begin
      rdata_s = mem_r[idx_s];
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.bus_rdata = rdata_s;
  assign bus.busy      = busy_s;
  assign bus.err       = err_r;
  assign bus.err_addr  = err_addr_r;
endmodule

// File: tb/tb_rambus_ram.sv
// tb_rambus_ram: directed stimulus for rambus_ram (DEPTH=16, BASE=0).
// Read expectations are queued by the stimulus and popped by a monitor on
// every falling edge that presents bus_re; status is checked inline.
module tb_rambus_ram;
  logic clk;
  logic rst;
  rambus_ram_if bus ();

  rambus_ram #(.DEPTH(16), .BASE_ADDR(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_pass;
  int          n_total;
  logic [31:0] rd_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: every presented read is compared with the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.bus_re === 1'b1) begin
      if (rd_q.size() == 0) begin
        chk("rd_q_underflow", 32'd1, 32'd0);
      end else begin
        chk("rdata", bus.bus_rdata, rd_q.pop_front());
      end
    end
  end

  task automatic idle_in();
    bus.bus_re    = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = 32'h0;
    bus.bus_wstrb = 4'h0;
    bus.bus_wdata = 32'h0;
    bus.err_clr   = 1'b0;
  endtask

  // One bus cycle; called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input logic re, input logic we, input logic [31:0] addr,
                     input logic [3:0] strb, input logic [31:0] wdata, input logic clr);
    bus.bus_re    = re;
    bus.bus_we    = we;
    bus.bus_addr  = addr;
    bus.bus_wstrb = strb;
    bus.bus_wdata = wdata;
    bus.err_clr   = clr;
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] req);
    rd_q.push_back(req);
    cyc(1'b1, 1'b0, addr, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata);
    cyc(1'b0, 1'b1, addr, strb, wdata, 1'b0);
  endtask

  // Counts edges until busy drops, bounded so a stuck scrub cannot hang.
  task automatic wait_scrub(input string name);
    int n;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.busy) break;
    end
    chk(name, 32'(n), 32'd16);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    n_pass  = 0;
    n_total = 0;
    idle_in();
    rst = 1'b1;

    // Reset values, including a read presented during reset.
    bus.bus_re = 1'b1;
    rd_q.push_back(32'h0);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_err_addr", bus.err_addr, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.bus_re = 1'b0;
    rst = 1'b0;
    wait_scrub("scrub_edges_first");

    // Fill with garbage, then reset: every word must read back zero.
    for (int i = 0; i < 16; i++) wr(32'(i * 4), 4'hF, 32'hA5A5_0000 | 32'(i));
    rd(32'h14, 32'hA5A5_0005);
    pulse_rst();
    wait_scrub("scrub_edges_refill");
    for (int i = 0; i < 16; i++) rd(32'(i * 4), 32'h0);

    // Single byte lane write, then aligned and unaligned reads of the word.
    wr(32'h4, 4'hF, 32'h1122_3344);
    wr(32'h5, 4'b0010, 32'h0000_AB00);
    rd(32'h4, 32'h1122_AB44);
    rd(32'h7, 32'h1122_AB44);

    // Upper half write with a same-cycle read of the old contents.
    wr(32'h8, 4'hF, 32'hDEAD_BEEF);
    rd_q.push_back(32'hDEAD_BEEF);
    cyc(1'b1, 1'b1, 32'hA, 4'b1100, 32'h1234_0000, 1'b0);
    rd(32'h8, 32'h1234_BEEF);
    wr(32'h8, 4'h0, 32'hFFFF_FFFF);
    rd(32'h8, 32'h1234_BEEF);
    chk("strb0_no_err", 32'(bus.err), 32'd0);

    // Out of range write, later read, then clear racing with a new error.
    wr(32'h40, 4'hF, 32'hFFFF_FFFF);
    chk("oor_err", 32'(bus.err), 32'd1);
    chk("oor_err_addr", bus.err_addr, 32'h40);
    rd(32'h0, 32'h0);
    rd(32'h80, 32'h0);
    chk("oor_sticky_addr", bus.err_addr, 32'h40);
    rd_q.push_back(32'h0);
    cyc(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, 1'b1);
    chk("clr_new_err", 32'(bus.err), 32'd1);
    chk("clr_new_err_addr", bus.err_addr, 32'h44);
    cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    chk("clr_err", 32'(bus.err), 32'd0);
    chk("clr_err_addr", bus.err_addr, 32'h0);

    // Reset mid-scrub at scrub_idx 7: scrub restarts in full.
    pulse_rst();
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midscrub_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_scrub("scrub_edges_midscrub");

    // Reset in READY during a write with a pending error.
    wr(32'h40, 4'hF, 32'h0);
    chk("pre_rst_err", 32'(bus.err), 32'd1);
    bus.bus_re    = 1'b1;
    bus.bus_we    = 1'b1;
    bus.bus_addr  = 32'hC;
    bus.bus_wstrb = 4'hF;
    bus.bus_wdata = 32'h1234_5678;
    rd_q.push_back(32'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("midwr_busy", 32'(bus.busy), 32'd1);
    chk("midwr_err", 32'(bus.err), 32'd0);
    chk("midwr_err_addr", bus.err_addr, 32'h0);
    chk("midwr_rdata", bus.bus_rdata, 32'h0);
    @(posedge clk); #1;
    idle_in();
    rst = 1'b0;
    wait_scrub("scrub_edges_midwr");
    rd(32'hC, 32'h0);

    // Accesses while scrubbing are ignored and raise no error.
    rst = 1'b1;
    @(posedge clk); #1;
    bus.bus_re    = 1'b1;
    bus.bus_we    = 1'b1;
    bus.bus_addr  = 32'h0;
    bus.bus_wstrb = 4'hF;
    bus.bus_wdata = 32'hFFFF_FFFF;
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      rd_q.push_back(32'h0);
      @(posedge clk);
      #1;
      n++;
      if (!bus.busy) break;
    end
    idle_in();
    chk("scrub_edges_access", 32'(n), 32'd16);
    chk("scrub_access_err", 32'(bus.err), 32'd0);
    rd(32'h0, 32'h0);

    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
